// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the receiver FSM state encoding, the parity-type constants used to
// decode par_typ, and a helper that locates the centre tick of a bit period
// for a given oversampling ratio.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Centre tick of a bit period; the vote uses this tick and its two neighbours.
  function automatic int unsigned vote_mid(input int unsigned oversample);
    return oversample / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: line synchronizer, bit-period tick counter
// and 3-sample majority vote.
// Ports:
//   clk, RST    clock and synchronous active-high reset
//   rx_in       raw asynchronous serial line (idle high)
//   idle        high while the receiver FSM sits in IDLE
//   rx_s        synchronized line value
//   bit_val     majority of rx_s at ticks MID-1, MID and the current tick
//   sample_stb  high at tick MID+1, when bit_val is the vote for this bit
//   bit_end     high at the last tick of a bit period
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_WIDTH  = $clog2(OVERSAMPLE)
) (
  input  logic clk,
  input  logic RST,
  input  logic rx_in,
  input  logic idle,
  output logic rx_s,
  output logic bit_val,
  output logic sample_stb,
  output logic bit_end
);

  localparam int MID = int'(vote_mid(OVERSAMPLE));
  localparam logic [CNT_WIDTH-1:0] TICK_EARLY = CNT_WIDTH'(MID - 1);
  localparam logic [CNT_WIDTH-1:0] TICK_MID   = CNT_WIDTH'(MID);
  localparam logic [CNT_WIDTH-1:0] TICK_LATE  = CNT_WIDTH'(MID + 1);
  localparam logic [CNT_WIDTH-1:0] TICK_LAST  = CNT_WIDTH'(OVERSAMPLE - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 early_q, early_d;
  logic                 mid_q, mid_d;
  logic [CNT_WIDTH-1:0] tick_q, tick_d;

  // While idle the counter parks at 0. The cycle in which the falling edge is
  // first seen counts as tick 0 of the start bit, so the counter leaves IDLE
  // already at 1 and every later tick lines up with the edge.
  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
    early_d = (tick_q == TICK_EARLY) ? sync2_q : early_q;
    mid_d   = (tick_q == TICK_MID)   ? sync2_q : mid_q;
    if (idle) begin
      tick_d = sync2_q ? '0 : CNT_WIDTH'(1);
    end else if (tick_q == TICK_LAST) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      early_q <= 1'b1;
      mid_q   <= 1'b1;
      tick_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      early_q <= early_d;
      mid_q   <= mid_d;
      tick_q  <= tick_d;
    end
  end

  // The third sample is the live synchronized value at tick MID+1.
  assign rx_s       = sync2_q;
  assign bit_val    = (early_q & mid_q) | (early_q & sync2_q) | (mid_q & sync2_q);
  assign sample_stb = !idle && (tick_q == TICK_LATE);
  assign bit_end    = !idle && (tick_q == TICK_LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: turns the oversampled serial line into parallel words.
// Detects the start bit, shifts in DATA_WIDTH bits LSB first, checks an
// optional parity bit and the stop bit, then reports one status pulse.
// Ports:
//   clk, RST    clock and synchronous active-high reset
//   rx_in       asynchronous serial line, idle high
//   par_en      frame carries a parity bit (latched at frame start)
//   par_typ     0 even, 1 odd parity (latched at frame start)
//   p_data      last word received without error
//   data_valid  one-cycle pulse, p_data updated
//   par_err     one-cycle pulse, parity mismatch
//   stp_err     one-cycle pulse, stop bit sampled low
//   busy        receiver is not idle
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int CNT_WIDTH     = $clog2(OVERSAMPLE),
  parameter int BIT_CNT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam logic [BIT_CNT_WIDTH-1:0] BIT_LAST = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                   state_q, state_d;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]    shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]    p_data_q, p_data_d;
  logic                     par_en_q, par_en_d;
  logic                     par_typ_q, par_typ_d;
  logic                     par_bad_q, par_bad_d;
  logic                     data_valid_q, data_valid_d;
  logic                     par_err_q, par_err_d;
  logic                     stp_err_q, stp_err_d;
  logic                     exp_par;

  logic rx_s;
  logic bit_val;
  logic sample_stb;
  logic bit_end;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_sampler (
    .clk        (clk),
    .RST        (RST),
    .rx_in      (rx_in),
    .idle       (state_q == IDLE),
    .rx_s       (rx_s),
    .bit_val    (bit_val),
    .sample_stb (sample_stb),
    .bit_end    (bit_end)
  );

  assign exp_par = (par_typ_q == PAR_ODD) ? ~^shreg_q : ^shreg_q;

  // Next-state and output logic. The stop bit is judged at its vote tick
  // rather than its end, which leaves the rest of the stop bit as slack for
  // the next start edge of a back-to-back frame.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    p_data_d     = p_data_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_bad_d    = par_bad_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          par_en_d  = par_en;
          par_typ_d = par_typ;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (sample_stb && bit_val) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample_stb) begin
          shreg_d[bit_cnt_q] = bit_val;
        end
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_WIDTH'(1);
          end
        end
      end
      PARITY: begin
        if (sample_stb) begin
          par_bad_d = (bit_val != exp_par);
        end
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample_stb) begin
          if (bit_val) begin
            state_d = IDLE;
            if (par_bad_q) begin
              par_err_d = 1'b1;
            end else begin
              data_valid_d = 1'b1;
              p_data_d     = shreg_q;
            end
          end else begin
            state_d   = WAIT_IDLE;
            stp_err_d = 1'b1;
            par_err_d = par_bad_q;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      p_data_q     <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      p_data_q     <= p_data_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_bad_q    <= par_bad_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer.
// Frames are driven onto rx_in at the bit level; a frame-level model decides
// which status pulse each frame must produce, when it must appear and which
// word p_data must hold, and a monitor records every pulse for comparison.
module tb_uart_rx_deserializer;

  localparam int DW  = 8;
  localparam int OS  = 16;
  localparam int MID = OS / 2;

  logic          clk = 1'b0;
  logic          RST;
  logic          rx_in;
  logic          par_en;
  logic          par_typ;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pdata_glitch = 0;
  logic [DW-1:0] exp_pdata = '0;
  logic [DW-1:0] prev_pd   = '0;
  logic          rst_at_edge = 1'b1;

  typedef struct {
    int          cyc;
    logic [2:0]  flags;
    logic [DW-1:0] pd;
  } ev_t;

  ev_t ev_q[$];
  ev_t exp_q[$];

  uart_rx_deserializer #(
    .DATA_WIDTH (DW),
    .OVERSAMPLE (OS)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .rx_in      (rx_in),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Cycle count advances on every active edge.
  always @(posedge clk) begin
    cyc++;
    rst_at_edge = RST;
  end

  // Record every status pulse and watch for p_data moving without data_valid.
  always @(negedge clk) begin
    if (data_valid || par_err || stp_err)
      ev_q.push_back('{cyc: cyc, flags: {data_valid, par_err, stp_err}, pd: p_data});
    if (!rst_at_edge && (p_data !== prev_pd) && !data_valid)
      pdata_glitch++;
    prev_pd = p_data;
  end

  // Frame-level reference: a frame is good when its stop bit is high and, if
  // parity is on, the total count of ones including the parity bit matches
  // the parity type.
  function automatic logic [2:0] model_frame(input logic [DW-1:0] d, input logic wp,
                                             input logic ptyp, input logic pbit,
                                             input logic sbit);
    int   ones;
    logic par_ok;
    ones   = $countones(d) + int'(pbit);
    par_ok = !wp || ((ones % 2) == (ptyp ? 1 : 0));
    return {sbit && par_ok, !par_ok, !sbit};
  endfunction

  // Cycle of the pulse: 2 synchronizer stages, 1 detect edge, then the vote
  // tick of the stop bit, after which the pulse register shows the result.
  function automatic int exp_cycle(input int start_cyc, input logic wp);
    return start_cyc + 3 + OS * (1 + DW + int'(wp)) + MID + 1;
  endfunction

  function automatic logic frame_bit(input logic [DW-1:0] d, input int idx);
    if (idx == 0) return 1'b0;
    return d[idx-1];
  endfunction

  task automatic send_frame(input logic [DW-1:0] d, input logic wp, input logic pbit,
                            input logic sbit, input int stop_len, input logic scramble,
                            output int start_cyc);
    @(negedge clk);
    start_cyc = cyc;
    rx_in = 1'b0;
    for (int k = 1; k < OS; k++) begin
      @(negedge clk);
      if (scramble && k == 8) begin
        par_en  = ~par_en;
        par_typ = ~par_typ;
      end
    end
    for (int i = 0; i < DW; i++)
      for (int k = 0; k < OS; k++) begin
        @(negedge clk);
        rx_in = d[i];
      end
    if (wp)
      for (int k = 0; k < OS; k++) begin
        @(negedge clk);
        rx_in = pbit;
      end
    for (int k = 0; k < stop_len; k++) begin
      @(negedge clk);
      rx_in = sbit;
    end
  endtask

  task automatic line_high(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (p_data !== '0) begin bad++; $display("[TB] FAIL reset_pdata: got %h want 00", p_data); end
    total++;
    if ({data_valid, par_err, stp_err} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_pulses: got %b want 000", {data_valid, par_err, stp_err});
    end
    RST = 1'b0;
    exp_pdata = '0;
    line_high(5);
  endtask

  task automatic test_8n1();
    int s;
    ev_q.delete();
    par_en = 1'b0; par_typ = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, OS, 1'b0, s);
    line_high(20);
    total++;
    if (ev_q.size() != 1) begin
      bad++; $display("[TB] FAIL 8n1_count: got %0d pulses want 1", ev_q.size());
    end else begin
      total++;
      if (ev_q[0].cyc != exp_cycle(s, 1'b0)) begin
        bad++; $display("[TB] FAIL 8n1_time: got %0d want %0d", ev_q[0].cyc - s, exp_cycle(s, 1'b0) - s);
      end
      total++; if (ev_q[0].flags !== 3'b100) begin bad++; $display("[TB] FAIL 8n1_flags: got %b want 100", ev_q[0].flags); end
      total++; if (ev_q[0].pd !== 8'hA5) begin bad++; $display("[TB] FAIL 8n1_data: got %h want a5", ev_q[0].pd); end
    end
    exp_pdata = 8'hA5;
  endtask

  task automatic test_parity();
    int s1, s2;
    ev_q.delete();
    par_en = 1'b1; par_typ = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, OS + 4, 1'b0, s1);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, OS + 4, 1'b0, s2);
    line_high(20);
    total++;
    if (ev_q.size() != 2) begin
      bad++; $display("[TB] FAIL parity_count: got %0d pulses want 2", ev_q.size());
    end else begin
      total++; if (ev_q[0].flags !== 3'b100) begin bad++; $display("[TB] FAIL parity_good_flags: got %b want 100", ev_q[0].flags); end
      total++; if (ev_q[0].pd !== 8'h07) begin bad++; $display("[TB] FAIL parity_good_data: got %h want 07", ev_q[0].pd); end
      total++;
      if (ev_q[1].cyc != exp_cycle(s2, 1'b1)) begin
        bad++; $display("[TB] FAIL parity_time: got %0d want %0d", ev_q[1].cyc - s2, exp_cycle(s2, 1'b1) - s2);
      end
      total++; if (ev_q[1].flags !== 3'b010) begin bad++; $display("[TB] FAIL parity_bad_flags: got %b want 010", ev_q[1].flags); end
    end
    total++; if (p_data !== 8'h07) begin bad++; $display("[TB] FAIL parity_hold_data: got %h want 07", p_data); end
    exp_pdata = 8'h07;
  endtask

  task automatic test_glitch();
    int s;
    ev_q.delete();
    par_en = 1'b0;
    @(negedge clk);
    s = cyc;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rx_in = 1'b1;
    while (cyc < s + 5) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL glitch_busy_start: got %b want 1", busy); end
    line_high(30);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy_end: got %b want 0", busy); end
    total++; if (ev_q.size() != 0) begin bad++; $display("[TB] FAIL glitch_pulses: got %0d want 0", ev_q.size()); end
  endtask

  task automatic test_break();
    int s;
    ev_q.delete();
    par_en = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 200, 1'b0, s);
    total++;
    if (ev_q.size() != 1) begin
      bad++; $display("[TB] FAIL break_count: got %0d pulses want 1", ev_q.size());
    end else begin
      total++; if (ev_q[0].cyc != exp_cycle(s, 1'b0)) begin bad++; $display("[TB] FAIL break_time: got %0d want %0d", ev_q[0].cyc - s, exp_cycle(s, 1'b0) - s); end
      total++; if (ev_q[0].flags !== 3'b001) begin bad++; $display("[TB] FAIL break_flags: got %b want 001", ev_q[0].flags); end
      total++; if (ev_q[0].pd !== exp_pdata) begin bad++; $display("[TB] FAIL break_data: got %h want %h", ev_q[0].pd, exp_pdata); end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL break_wait_busy: got %b want 1", busy); end
    line_high(10);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL break_release: got %b want 0", busy); end
    ev_q.delete();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, OS, 1'b0, s);
    line_high(20);
    total++;
    if (ev_q.size() != 1) begin
      bad++; $display("[TB] FAIL break_next_count: got %0d want 1", ev_q.size());
    end else begin
      total++;
      if ({ev_q[0].flags, ev_q[0].pd} !== {3'b100, 8'h3C}) begin
        bad++; $display("[TB] FAIL break_next_frame: got %b/%h want 100/3c", ev_q[0].flags, ev_q[0].pd);
      end
    end
    exp_pdata = 8'h3C;
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    ev_q.delete();
    par_en = 1'b0;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, OS, 1'b0, s1);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, OS, 1'b0, s2);
    line_high(20);
    total++;
    if (ev_q.size() != 2) begin
      bad++; $display("[TB] FAIL b2b_count: got %0d want 2", ev_q.size());
    end else begin
      total++; if (ev_q[0].cyc != exp_cycle(s1, 1'b0)) begin bad++; $display("[TB] FAIL b2b_time: got %0d want %0d", ev_q[0].cyc - s1, exp_cycle(s1, 1'b0) - s1); end
      total++; if (ev_q[1].cyc - ev_q[0].cyc != 160) begin bad++; $display("[TB] FAIL b2b_spacing: got %0d want 160", ev_q[1].cyc - ev_q[0].cyc); end
      total++; if ({ev_q[0].flags, ev_q[0].pd} !== {3'b100, 8'h55}) begin bad++; $display("[TB] FAIL b2b_first: got %b/%h want 100/55", ev_q[0].flags, ev_q[0].pd); end
      total++; if ({ev_q[1].flags, ev_q[1].pd} !== {3'b100, 8'hAA}) begin bad++; $display("[TB] FAIL b2b_second: got %b/%h want 100/aa", ev_q[1].flags, ev_q[1].pd); end
    end
    exp_pdata = 8'hAA;
  endtask

  task automatic test_reset_mid_frame();
    int s;
    ev_q.delete();
    par_en = 1'b0;
    // Drive up to the middle of data bit 4 (frame bit 5), then pulse reset.
    for (int k = 0; k <= 88; k++) begin
      @(negedge clk);
      if (k == 0) s = cyc;
      rx_in = frame_bit(8'hC3, k / OS);
    end
    RST = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
    total++; if (p_data !== '0) begin bad++; $display("[TB] FAIL midrst_pdata: got %h want 00", p_data); end
    RST = 1'b0;
    exp_pdata = '0;
    line_high(80);
    total++; if (ev_q.size() != 0) begin bad++; $display("[TB] FAIL midrst_pulses: got %0d want 0", ev_q.size()); end
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, OS, 1'b0, s);
    line_high(20);
    total++;
    if (ev_q.size() != 1) begin
      bad++; $display("[TB] FAIL midrst_next_count: got %0d want 1", ev_q.size());
    end else begin
      total++;
      if ({ev_q[0].flags, ev_q[0].pd} !== {3'b100, 8'h81}) begin
        bad++; $display("[TB] FAIL midrst_next_frame: got %b/%h want 100/81", ev_q[0].flags, ev_q[0].pd);
      end
    end
    exp_pdata = 8'h81;
  endtask

  task automatic test_random();
    int            s;
    logic [DW-1:0] d;
    logic          wp, ptyp, pbit, sbit, scr;
    logic [2:0]    fl;
    ev_q.delete();
    exp_q.delete();
    for (int n = 0; n < 14; n++) begin
      d    = DW'($urandom);
      wp   = 1'($urandom);
      ptyp = 1'($urandom);
      pbit = 1'(($countones(d) % 2)) ^ ptyp;
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      sbit = ($urandom_range(0, 5) != 0);
      scr  = 1'($urandom);
      par_en  = wp;
      par_typ = ptyp;
      fl = model_frame(d, wp, ptyp, pbit, sbit);
      if (sbit) send_frame(d, wp, pbit, 1'b1, OS + int'($urandom_range(0, 6)), scr, s);
      else begin
        send_frame(d, wp, pbit, 1'b0, OS, scr, s);
        line_high(4);
      end
      if (fl[2]) exp_pdata = d;
      exp_q.push_back('{cyc: exp_cycle(s, wp), flags: fl, pd: exp_pdata});
    end
    line_high(30);
    total++;
    if (ev_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL rand_count: got %0d want %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      total++;
      if (ev_q[i] != exp_q[i]) begin
        bad++;
        $display("[TB] FAIL rand_frame%0d: got cyc=%0d flags=%b pd=%h want cyc=%0d flags=%b pd=%h",
                 i, ev_q[i].cyc, ev_q[i].flags, ev_q[i].pd, exp_q[i].cyc, exp_q[i].flags, exp_q[i].pd);
      end
    end
  endtask

  task automatic test_p_data_stable();
    total++; if (p_data !== exp_pdata) begin bad++; $display("[TB] FAIL final_pdata: got %h want %h", p_data, exp_pdata); end
    total++; if (pdata_glitch != 0) begin bad++; $display("[TB] FAIL pdata_without_valid: got %0d changes want 0", pdata_glitch); end
  endtask

  initial begin
    RST     = 1'b1;
    rx_in   = 1'b1;
    par_en  = 1'b0;
    par_typ = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_p_data_stable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
